// File: rtl/multi_cyc_sched.sv
// Round-robin scheduler and latency sequencer for the shared multi-cycle mul/div unit.
// Latches the winning pipe's operands, counts the unit latency and hands the result back via done/ack.
module multi_cyc_sched #(
  parameter int MUL_CYC = 2,
  parameter int DIV_CYC = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_is_div,
  input  logic [31:0] req0_reg1,
  input  logic [31:0] req0_reg2,
  input  logic [31:0] req1_reg1,
  input  logic [31:0] req1_reg2,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        unit_en,
  output logic        unit_src,
  output logic        unit_is_div,
  output logic [31:0] unit_reg1,
  output logic [31:0] unit_reg2,
  input  logic [63:0] unit_result,
  output logic        done,
  output logic        done_id,
  output logic [63:0] result,
  input  logic        done_ack
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [5:0] MUL_LD = 6'(MUL_CYC - 1);
  localparam logic [5:0] DIV_LD = 6'(DIV_CYC - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        src_q, src_d;
  logic        is_div_q, is_div_d;
  logic [31:0] reg1_q, reg1_d;
  logic [31:0] reg2_q, reg2_d;
  logic [63:0] result_q, result_d;
  logic        done_id_q, done_id_d;
  logic [1:0]  grant_w;
  logic        win;

  // On a tie the pipe not granted last time wins; last resets to 1 so pipe 0 wins first.
  assign win = (req_valid == 2'b11) ? ~last_q : req_valid[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    src_d     = src_q;
    is_div_d  = is_div_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;
    result_d  = result_q;
    done_id_d = done_id_q;
    grant_w   = '0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid != '0) begin
            grant_w  = win ? 2'b10 : 2'b01;
            last_d   = win;
            src_d    = win;
            is_div_d = req_is_div[win];
            reg1_d   = win ? req1_reg1 : req0_reg1;
            reg2_d   = win ? req1_reg2 : req0_reg2;
            cnt_d    = req_is_div[win] ? DIV_LD : MUL_LD;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            result_d  = unit_result;
            done_id_d = src_q;
            state_d   = DONE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        DONE: begin
          if (done_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      src_q     <= 1'b0;
      is_div_q  <= 1'b0;
      reg1_q    <= '0;
      reg2_q    <= '0;
      result_q  <= '0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      src_q     <= src_d;
      is_div_q  <= is_div_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
    end
  end

  // Grant is suppressed during reset since nothing would be latched at that edge.
  assign grant       = rst ? 2'b00 : grant_w;
  assign busy        = (state_q != IDLE);
  assign unit_en     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign unit_src    = src_q;
  assign unit_is_div = is_div_q;
  assign unit_reg1   = reg1_q;
  assign unit_reg2   = reg2_q;
  assign result      = result_q;
  assign done_id     = done_id_q;

endmodule

// File: tb/tb_multi_cyc_sched.sv
// Directed bench for multi_cyc_sched with a stub unit that drives its result only in the last RUN cycle.
module tb_multi_cyc_sched;

  logic        clk = 1'b0;
  logic        rst, flush, done_ack;
  logic [1:0]  req_valid, req_is_div, grant;
  logic [31:0] req0_reg1, req0_reg2, req1_reg1, req1_reg2;
  logic        busy, unit_en, unit_src, unit_is_div, done, done_id;
  logic [31:0] unit_reg1, unit_reg2;
  logic [63:0] unit_result, result, stub_val, prod;
  logic signed [63:0] sa, sb;
  int          checks = 0;
  int          failures = 0;
  int          rc = 0;
  int          stub_lat;

  always #5 clk = ~clk;

  multi_cyc_sched #(.MUL_CYC(2), .DIV_CYC(36)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_is_div(req_is_div),
    .req0_reg1(req0_reg1), .req0_reg2(req0_reg2),
    .req1_reg1(req1_reg1), .req1_reg2(req1_reg2),
    .grant(grant), .busy(busy), .unit_en(unit_en), .unit_src(unit_src),
    .unit_is_div(unit_is_div), .unit_reg1(unit_reg1), .unit_reg2(unit_reg2),
    .unit_result(unit_result), .done(done), .done_id(done_id),
    .result(result), .done_ack(done_ack)
  );

  // Stub unit: signed 32x32 multiply or {remainder, quotient}, valid only in its last cycle.
  always @(posedge clk) rc <= unit_en ? rc + 1 : 0;
  assign sa       = {{32{unit_reg1[31]}}, unit_reg1};
  assign sb       = {{32{unit_reg2[31]}}, unit_reg2};
  assign prod     = sa * sb;
  assign stub_val = unit_is_div ? {unit_reg1 % unit_reg2, unit_reg1 / unit_reg2} : prod;
  assign stub_lat = unit_is_div ? 36 : 2;
  assign unit_result = (unit_en && rc == stub_lat - 1) ? stub_val : 64'hDEAD_BEEF_0BAD_F00D;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {64'(grant), busy, unit_en, unit_src, unit_is_div, done, done_id}, '0);
    chk({tag, "_regs"}, {unit_reg1, unit_reg2}, '0);
    chk({tag, "_res"}, result, '0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; done_ack = 1'b0;
    req_valid = '0; req_is_div = '0;
    req0_reg1 = '0; req0_reg2 = '0; req1_reg1 = '0; req1_reg2 = '0;
    step(); step();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Multiply on pipe 0: 3 * -2
    step();
    req_valid = 2'b01; req0_reg1 = 32'h0000_0003; req0_reg2 = 32'hFFFF_FFFE;
    #1 chk("t1_grant", 64'(grant), 64'(2'b01));
    step();
    req_valid = 2'b00;
    #1 chk("t1_run1", {busy, unit_en, grant}, 4'b1100);
    chk("t1_regs", {unit_reg1, unit_reg2}, {32'h3, 32'hFFFF_FFFE});
    step();
    chk("t1_run2", {unit_en, done}, 2'b10);
    step();
    chk("t1_done", {done, unit_en, done_id}, 3'b100);
    chk("t1_result", result, 64'hFFFF_FFFF_FFFF_FFFA);
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    chk("t1_idle", {busy, done}, 2'b00);

    // Both pipes tie out of reset, ack held high: grants alternate every 4 cycles
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 2'b11; req1_reg1 = 32'd5; req1_reg2 = 32'd6; done_ack = 1'b1;
    #1 chk("t2_first", 64'(grant), 64'(2'b01));
    step();
    chk("t2_busy_nogrant", 64'(grant), 64'(2'b00));
    step(); step(); step();
    chk("t2_alt", 64'(grant), 64'(2'b10));
    for (int k = 2; k <= 3; k++) begin
      repeat (4) step();
      chk("t2_alt", 64'(grant), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
    end
    step();
    req_valid = 2'b00;
    repeat (3) step();
    done_ack = 1'b0;
    chk("t2_idle", 64'(busy), 64'(1'b0));

    // Divide on pipe 1: 100 / 7
    req_valid = 2'b10; req_is_div = 2'b10; req1_reg1 = 32'd100; req1_reg2 = 32'd7;
    #1 chk("t3_grant", 64'(grant), 64'(2'b10));
    for (int i = 0; i < 36; i++) begin
      step();
      if (i == 0) req_valid = 2'b00;
      chk("t3_run", {unit_en, unit_src, unit_is_div, done}, 4'b1110);
      chk("t3_regs", {unit_reg1, unit_reg2}, {32'd100, 32'd7});
    end
    step();
    chk("t3_done", {unit_en, done, done_id}, 3'b011);
    chk("t3_result", result, {32'd2, 32'd14});
    done_ack = 1'b1;
    step();
    done_ack = 1'b0; req_is_div = 2'b00;

    // Flush in IDLE suppresses the grant
    flush = 1'b1; req_valid = 2'b01;
    #1 chk("t4_idle_flush", 64'(grant), 64'(2'b00));
    step();
    flush = 1'b0;

    // Flush at T+10 of a divide, then a new mul granted at T+11
    req_valid = 2'b01; req_is_div = 2'b01; req0_reg1 = 32'd50; req0_reg2 = 32'd3;
    #1 chk("t4_grant", 64'(grant), 64'(2'b01));
    step();
    req_valid = 2'b00;
    repeat (9) step();
    flush = 1'b1; req_valid = 2'b01; req_is_div = 2'b00; req0_reg1 = 32'd7; req0_reg2 = 32'd9;
    #1 chk("t4_flush_nogrant", 64'(grant), 64'(2'b00));
    step();
    flush = 1'b0;
    #1 chk("t4_aborted", {busy, unit_en}, 2'b00);
    chk("t4_regrant", 64'(grant), 64'(2'b01));
    step();
    req_valid = 2'b10; req1_reg1 = 32'd4; req1_reg2 = 32'd5;
    #1 chk("t4_nodone", {done, grant}, 3'b000);
    step();
    chk("t4_nodone", {done, grant}, 3'b000);
    step();

    // Ack held low for 5 DONE cycles with pipe 1 pending
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold", {done, done_id, grant}, 4'b1000);
      chk("t5_result", result, 64'd63);
      step();
    end
    done_ack = 1'b1;
    #1 chk("t5_ack_nogrant", {done, grant}, 3'b100);
    step();
    done_ack = 1'b0;
    #1 chk("t5_next_grant", 64'(grant), 64'(2'b10));
    step();
    req_valid = 2'b00;
    step(); step();
    chk("t5_done2", {done, done_id}, 2'b11);
    chk("t5_result2", result, 64'd20);
    flush = 1'b1; done_ack = 1'b1;
    step();
    flush = 1'b0; done_ack = 1'b0;
    chk("t5_flush_ack", {busy, done}, 2'b00);

    // Reset in RUN cycle 1 of a pipe-0 mul; last must return to 1
    req_valid = 2'b01; req0_reg1 = 32'h11; req0_reg2 = 32'h22;
    #1 chk("t6_grant", 64'(grant), 64'(2'b01));
    step();
    req_valid = 2'b00; rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("t6_rst");
    req_valid = 2'b11;
    #1 chk("t6_tie_after_rst", 64'(grant), 64'(2'b01));
    step();
    req_valid = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cyc_sched.md
# multi_cyc_sched

Scheduler and sequencer for the shared multi-cycle multiply/divide unit in the EX stage. It sits between the two issue pipes, which both request the unit, and the unit itself, which needs its operation and operands held stable for its full latency. It arbitrates round-robin between the pipes and latches the winner's operands. It counts the fixed unit latency, captures the 64-bit result and presents it with a done/ack handshake. Any in-flight operation is dropped on pipeline flush.

## Interface
- `MUL_CYC`, default 2: cycles the unit needs for multiply-class ops.
- `DIV_CYC`, default 36: cycles the unit needs for divide-class ops.
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline flush; aborts any operation.
- `req_valid`  in  2  per-pipe request; bit i belongs to pipe i.
- `req_is_div`  in  2  per-pipe op class: 1 = divide, 0 = multiply.
- `req0_reg1`, `req0_reg2`  in  32 each  pipe 0 operands.
- `req1_reg1`, `req1_reg2`  in  32 each  pipe 1 operands.
- `grant`  out  2  one-hot, combinational; the request is accepted in this cycle.
- `busy`  out  1  high when the state is not IDLE.
- `unit_en`  out  1  high while the unit is executing (RUN).
- `unit_src`  out  1  id of the pipe that owns the unit; used by upstream to mux the opcode.
- `unit_is_div`  out  1  latched op class.
- `unit_reg1`, `unit_reg2`  out  32 each  latched operands, stable through RUN.
- `unit_result`  in  64  unit output, valid in the last RUN cycle.
- `done`  out  1  result available.
- `done_id`  out  1  pipe that owns the result.
- `result`  out  64  captured result.
- `done_ack`  in  1  consumer accepts the result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - When any `req_valid` bit is high and `flush` is low, assert `grant`.
  - Latch the winner's id, class and operands.
  - Load `cnt` with `(is_div ? DIV_CYC : MUL_CYC) - 1`, then go to RUN.
- Arbitration:
  - A single valid request wins.
  - When both are valid, the pipe that was not granted last wins.
  - `last` resets to 1, so pipe 0 wins the first tie.
  - `last` updates only on a grant.
- RUN:
  - `unit_en` = 1 and the `unit_*` outputs are held constant.
  - `cnt` decrements each cycle.
  - When `cnt == 0`, register `unit_result` into `result` and go to DONE.
- DONE:
  - `done` = 1; `result` and `done_id` are held.
  - `done_ack` = 1 returns to IDLE.
  - No grant is issued in DONE, including in the ack cycle.
- Flush: in any state the next state is IDLE, `done` is never raised for the aborted op, and `grant` is forced to 0 in the flush cycle. `last` is unchanged.
- Requests seen while `busy` get no grant; the requester holds `req_valid` until it is granted.
- `cnt` is 6 bits wide. The block does no arithmetic on the data; sign handling is the unit's job.

## Timing
- Reset values:
  - `grant`, `busy`, `unit_en`, `unit_src`, `unit_is_div`, `done`, `done_id` = 0.
  - `unit_reg1`, `unit_reg2`, `result` = 0.
  - State = IDLE, `cnt` = 0, `last` = 1.
- A grant in cycle T gives `unit_en` = 1 in cycles T+1 .. T+L, where L is `MUL_CYC` or `DIV_CYC`.
- The result is captured at the edge ending T+L, so `done` = 1 from T+L+1.
- Multiply: grant to done is 3 cycles. Divide: grant to done is 37 cycles.
- An ack in cycle D means IDLE at D+1; the earliest next grant is D+1.
- Back-to-back throughput is therefore L+2 cycles per op when the ack is immediate.
- `rst` has priority over `flush`; both take effect at the next edge.
- Reset or flush mid-RUN: `unit_en` = 0 and `busy` = 0 from the next cycle.
- `flush` and `done_ack` in the same cycle: IDLE next, same as ack alone.

## Test plan
- Mul on pipe 0, `reg1` = 0x0000_0003, `reg2` = 0xFFFF_FFFE: the bench's stub unit drives `unit_result` = 0xFFFF_FFFF_FFFF_FFFA in the last RUN cycle.
  - Required: `grant` = 01 at T; `unit_en` high at T+1..T+2; `done` = 1 with `done_id` = 0 and that `result` at T+3.
  - Ack at T+3: `busy` = 0 at T+4.
- Both pipes request a mul out of reset with ack held high:
  - Grant 01 at T0 and 10 at T0+4.
  - With pipe 0 re-requesting continuously, the grants keep alternating 01/10/01.
- Div on pipe 1, 100 / 7:
  - `unit_en` high for exactly 36 cycles with `unit_reg1` and `unit_reg2` constant.
  - `done` at T+37 with `result` = {remainder 2, quotient 14} (stub-driven).
- Flush at cycle T+10 of a div:
  - `busy` = 0 and `unit_en` = 0 at T+11; `done` is never asserted.
  - A new pipe-0 request is granted at T+11.
- Ack held low for 5 cycles in DONE:
  - `result` and `done_id` stay stable; a pending pipe-1 request gets no grant.
  - Ack at the 6th cycle: grant the next cycle.
- `rst` pulsed at RUN cycle 1 of a mul: all outputs return to their reset values on the next cycle, and `done` is never raised.
